// File: rtl/req_initiator_pkg.sv
// Shared types and widths for the two-channel request initiator.
package req_initiator_pkg;

  localparam int BEAT_W = 4;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_RELEASE
  } chan_state_e;

  // A zero-length job still moves one beat.
  function automatic logic [BEAT_W-1:0] norm_len(input logic [BEAT_W-1:0] len);
    return (len == '0) ? BEAT_W'(1) : len;
  endfunction

endpackage

// File: rtl/req_channel.sv
// One initiator channel: accepts a job, requests the arbiter, consumes granted
// beats, then waits for the grant to drop before reporting completion.
module req_channel
  import req_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              job_valid_i,
  input  logic [BEAT_W-1:0] job_len_i,
  input  logic              gnt_i,
  output logic              job_ready_o,
  output logic              req_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o
);

  chan_state_e       state_q, state_d;
  logic [BEAT_W-1:0] rem_q, rem_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              timeout_q, timeout_d;
  logic              ready_en_q;

  // NOTE: reset is sampled on the clock edge here, and every flop uses <= so
  // all state updates see the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      wait_q     <= '0;
      timeout_q  <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      wait_q     <= wait_d;
      timeout_q  <= timeout_d;
      ready_en_q <= 1'b1;
    end
  end

  assign wait_inc = wait_q + 1'b1;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    wait_d      = wait_q;
    timeout_d   = timeout_q;
    job_ready_o = 1'b0;
    req_o       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // ready_en_q keeps job_ready low during the first cycle out of reset.
        job_ready_o = ready_en_q;
        if (job_valid_i && ready_en_q) begin
          state_d = ST_REQ;
          rem_d   = norm_len(job_len_i);
          wait_d  = '0;
        end
      end

      ST_REQ: begin
        req_o = 1'b1;
        if (gnt_i) begin
          state_d = ST_XFER;
          wait_d  = '0;
        end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
          state_d   = ST_IDLE;
          wait_d    = '0;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end

      ST_XFER: begin
        req_o  = 1'b1;
        busy_o = 1'b1;
        if (gnt_i) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == BEAT_W'(1)) state_d = ST_RELEASE;
        end else begin
          // Preempted: keep the remaining beats and start a fresh wait.
          state_d = ST_REQ;
          wait_d  = '0;
        end
      end

      ST_RELEASE: begin
        if (!gnt_i) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/req_initiator.sv
// Two independent request channels sharing a two-requester arbiter interface.
module req_initiator
  import req_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        job_valid,
  input  logic [BEAT_W-1:0] job_len0,
  input  logic [BEAT_W-1:0] job_len1,
  output logic [1:0]        job_ready,
  input  logic [1:0]        gnt,
  output logic [1:0]        req,
  output logic [1:0]        busy,
  output logic [1:0]        done,
  output logic [1:0]        timeout
);

  logic ch0_ready, ch0_req, ch0_busy, ch0_done, ch0_timeout;
  logic ch1_ready, ch1_req, ch1_busy, ch1_done, ch1_timeout;

  req_channel #(.TIMEOUT(TIMEOUT)) u_ch0 (
    .clk_i       (clock),
    .rst_ni      (reset),
    .job_valid_i (job_valid[0]),
    .job_len_i   (job_len0),
    .gnt_i       (gnt[0]),
    .job_ready_o (ch0_ready),
    .req_o       (ch0_req),
    .busy_o      (ch0_busy),
    .done_o      (ch0_done),
    .timeout_o   (ch0_timeout)
  );

  req_channel #(.TIMEOUT(TIMEOUT)) u_ch1 (
    .clk_i       (clock),
    .rst_ni      (reset),
    .job_valid_i (job_valid[1]),
    .job_len_i   (job_len1),
    .gnt_i       (gnt[1]),
    .job_ready_o (ch1_ready),
    .req_o       (ch1_req),
    .busy_o      (ch1_busy),
    .done_o      (ch1_done),
    .timeout_o   (ch1_timeout)
  );

  assign job_ready = {ch1_ready, ch0_ready};
  assign req       = {ch1_req, ch0_req};
  assign busy      = {ch1_busy, ch0_busy};
  assign done      = {ch1_done, ch0_done};
  assign timeout   = {ch1_timeout, ch0_timeout};

endmodule

// File: tb/tb_req_initiator.sv
// Bench for req_initiator: directed vector table, hand-built corner sequences,
// then randomized traffic against a job-level reference model.
module tb_req_initiator;

  localparam int TO = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] job_valid, gnt;
  logic [3:0] job_len0, job_len1;
  logic [1:0] job_ready, req, busy, done, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  req_initiator #(.TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .job_valid (job_valid),
    .job_len0  (job_len0),
    .job_len1  (job_len1),
    .job_ready (job_ready),
    .gnt       (gnt),
    .req       (req),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {req, busy, done, timeout, job_ready};
  endfunction

  task automatic step(input logic [1:0] jv, input logic [3:0] l0, input logic [3:0] l1,
                      input logic [1:0] g);
    @(negedge clock);
    job_valid = jv;
    job_len0  = l0;
    job_len1  = l1;
    gnt       = g;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset     = 1'b0;
    job_valid = '0;
    job_len0  = '0;
    job_len1  = '0;
    gnt       = '0;
    repeat (2) @(negedge clock);
    #1;
  endtask

  typedef struct {
    logic [1:0] jv;
    logic [3:0] l0;
    logic [3:0] l1;
    logic [1:0] g;
    logic [1:0] e_req;
    logic [1:0] e_busy;
    logic [1:0] e_done;
    logic [1:0] e_to;
    logic [1:0] e_rdy;
  } vec_t;

  vec_t tbl[21];

  // Reference model: a channel either owns a job (optionally holding the
  // grant), is winding down a finished job, or is free.
  bit m_have[2], m_hold[2], m_rel[2], m_to[2];
  int m_left[2], m_wait[2];
  bit m_run;

  initial begin
    int waited, beats, gpct[2];
    bit saw_done;
    logic [1:0] jv, g, e_req, e_busy, e_done, e_to, e_rdy;
    logic [3:0] l0, l1, len;
    logic rst_v;

    // {jv, len0, len1, gnt, req, busy, done, timeout, job_ready}
    tbl[0]  = '{2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{2'b01, 4'd3, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    tbl[2]  = '{2'b00, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    tbl[3]  = '{2'b00, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    tbl[4]  = '{2'b00, 4'd0, 4'd0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    tbl[5]  = '{2'b00, 4'd0, 4'd0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    tbl[6]  = '{2'b00, 4'd0, 4'd0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    tbl[7]  = '{2'b00, 4'd0, 4'd0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    tbl[8]  = '{2'b00, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    tbl[9]  = '{2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
    tbl[10] = '{2'b11, 4'd1, 4'd1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    tbl[11] = '{2'b00, 4'd0, 4'd0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[12] = '{2'b00, 4'd0, 4'd0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[13] = '{2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    tbl[14] = '{2'b01, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    tbl[15] = '{2'b00, 4'd0, 4'd0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    tbl[16] = '{2'b00, 4'd0, 4'd0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    tbl[17] = '{2'b00, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    tbl[18] = '{2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
    tbl[19] = '{2'b00, 4'd0, 4'd0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    tbl[20] = '{2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};

    reset = 1'b1;
    apply_reset();
    check("reset_outputs", 32'(outs()), 32'h0);

    // Directed table; reset is released as row 0 is applied.
    for (int i = 0; i < 21; i++) begin
      @(negedge clock);
      if (i == 0) reset = 1'b1;
      job_valid = tbl[i].jv;
      job_len0  = tbl[i].l0;
      job_len1  = tbl[i].l1;
      gnt       = tbl[i].g;
      #1;
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({tbl[i].e_req, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_to, tbl[i].e_rdy}));
    end

    // Channel 1 starves with no grant until it gives up.
    step(2'b10, 4'd0, 4'd5, 2'b00);
    check("to_accept_ready", 32'(job_ready), 32'h3);
    waited   = 0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(2'b00, 4'd0, 4'd0, 2'b00);
      if (done[1]) saw_done = 1'b1;
      if (!req[1]) break;
      waited++;
    end
    check("to_wait_cycles", 32'(waited), 32'(TO));
    check("to_sticky_set", 32'(timeout), 32'h2);
    check("to_ready_back", 32'(job_ready[1]), 32'h1);
    check("to_no_done", 32'(saw_done), 32'h0);

    // A new job is still taken and completes while timeout stays set.
    step(2'b10, 4'd0, 4'd2, 2'b00);
    step(2'b00, 4'd0, 4'd0, 2'b10);
    step(2'b00, 4'd0, 4'd0, 2'b10);
    step(2'b00, 4'd0, 4'd0, 2'b10);
    step(2'b00, 4'd0, 4'd0, 2'b00);
    check("to_job_after", 32'({done, timeout}), 32'({2'b10, 2'b10}));

    // Channel 0 len=4, preempted for 3 cycles after 2 beats.
    step(2'b01, 4'd4, 4'd0, 2'b00);
    step(2'b00, 4'd0, 4'd0, 2'b01);
    step(2'b00, 4'd0, 4'd0, 2'b01);
    step(2'b00, 4'd0, 4'd0, 2'b01);
    step(2'b00, 4'd0, 4'd0, 2'b00);
    check("pre_xfer_nogrant", 32'({req[0], busy[0]}), 32'h3);
    step(2'b00, 4'd0, 4'd0, 2'b00);
    check("pre_back_in_req", 32'({req[0], busy[0]}), 32'h2);
    step(2'b00, 4'd0, 4'd0, 2'b00);
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      step(2'b00, 4'd0, 4'd0, 2'b01);
      if (busy[0]) beats++;
      if (!req[0]) break;
    end
    check("pre_resume_beats", 32'(beats), 32'h2);
    step(2'b00, 4'd0, 4'd0, 2'b00);
    check("pre_done", 32'(done), 32'h1);

    // Reset in the middle of a len=8 transfer after 3 beats.
    step(2'b01, 4'd8, 4'd0, 2'b00);
    step(2'b00, 4'd0, 4'd0, 2'b01);
    repeat (3) step(2'b00, 4'd0, 4'd0, 2'b01);
    check("rst_mid_busy", 32'(busy), 32'h1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("rst_mid_outputs", 32'(outs()), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    gnt   = 2'b00;
    #1;
    check("rst_release_ready0", 32'(job_ready), 32'h0);
    step(2'b00, 4'd0, 4'd0, 2'b00);
    check("rst_release_ready1", 32'(job_ready), 32'h3);

    // Randomized traffic against the reference model.
    m_run = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      m_have[ch] = 0; m_hold[ch] = 0; m_rel[ch] = 0; m_to[ch] = 0;
      m_left[ch] = 0; m_wait[ch] = 0;
    end
    gpct[0] = 80;
    gpct[1] = 80;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 0) begin
        for (int ch = 0; ch < 2; ch++) begin
          case ($urandom_range(0, 3))
            0:       gpct[ch] = 0;
            1:       gpct[ch] = 40;
            2:       gpct[ch] = 80;
            default: gpct[ch] = 100;
          endcase
        end
      end
      rst_v = ($urandom_range(0, 399) != 0);
      for (int ch = 0; ch < 2; ch++) begin
        jv[ch] = ($urandom_range(0, 99) < 40);
        g[ch]  = ($urandom_range(0, 99) < gpct[ch]);
      end
      l0 = 4'($urandom_range(0, 15));
      l1 = 4'($urandom_range(0, 15));

      @(negedge clock);
      reset     = rst_v;
      job_valid = jv;
      job_len0  = l0;
      job_len1  = l1;
      gnt       = g;
      #1;

      for (int ch = 0; ch < 2; ch++) begin
        e_req[ch]  = m_have[ch];
        e_busy[ch] = m_have[ch] && m_hold[ch];
        e_done[ch] = m_rel[ch] && !g[ch];
        e_to[ch]   = m_to[ch];
        e_rdy[ch]  = m_run && !m_have[ch] && !m_rel[ch];
      end
      check($sformatf("rand%0d", cyc), 32'(outs()),
            32'({e_req, e_busy, e_done, e_to, e_rdy}));

      for (int ch = 0; ch < 2; ch++) begin
        len = (ch == 0) ? l0 : l1;
        if (!rst_v) begin
          m_have[ch] = 0; m_hold[ch] = 0; m_rel[ch] = 0; m_to[ch] = 0;
          m_left[ch] = 0; m_wait[ch] = 0;
        end else if (m_rel[ch]) begin
          if (!g[ch]) m_rel[ch] = 0;
        end else if (!m_have[ch]) begin
          if (jv[ch] && e_rdy[ch]) begin
            m_have[ch] = 1;
            m_hold[ch] = 0;
            m_wait[ch] = 0;
            m_left[ch] = (len == 0) ? 1 : int'(len);
          end
        end else if (m_hold[ch]) begin
          if (g[ch]) begin
            m_left[ch]--;
            if (m_left[ch] == 0) begin
              m_have[ch] = 0;
              m_hold[ch] = 0;
              m_rel[ch]  = 1;
            end
          end else begin
            m_hold[ch] = 0;
            m_wait[ch] = 0;
          end
        end else if (g[ch]) begin
          m_hold[ch] = 1;
          m_wait[ch] = 0;
        end else begin
          m_wait[ch]++;
          if (m_wait[ch] == TO) begin
            m_have[ch] = 0;
            m_to[ch]   = 1;
          end
        end
      end
      m_run = rst_v;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/req_initiator.md
REQ_INITIATOR -- requirements
Module: req_initiator

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum number of cycles a channel waits in REQ without a grant before it abandons the job (range 1..255).
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the rising edge of clock).
REQ-004 job_valid  input  2  per-channel job offer; bit i belongs to channel i.
REQ-005 job_len0, job_len1  input  4 each  beats requested for channel 0 / 1; sampled on job acceptance.
REQ-006 job_ready  output  2  channel i can accept a job.
REQ-007 gnt  input  2  grant from the two-requester arbiter; gnt[i] answers req[i].
REQ-008 req  output  2  request to the arbiter.
REQ-009 busy  output  2  channel i holds the grant and is consuming beats.
REQ-010 done  output  2  one-cycle pulse: channel i has completed its job and released the grant.
REQ-011 timeout  output  2  sticky error: channel i abandoned a job for lack of grant.

Function
REQ-012 Each channel runs an independent FSM with states IDLE, REQ, XFER and RELEASE; no state is shared between channels.
REQ-013 In IDLE: job_ready[i]=1 and req[i]=0; job_valid[i]&job_ready[i] captures job_len (value 0 treated as 1) and moves to REQ next cycle.
REQ-014 req[i]=1 in REQ and XFER and 0 in IDLE and RELEASE; the first req after acceptance is at cycle t+1.
REQ-015 In REQ: an 8-bit wait counter increments each cycle gnt[i]=0; gnt[i]=1 moves to XFER and clears the wait counter.
REQ-016 In REQ: when the wait counter reaches TIMEOUT with gnt[i]=0, the channel returns to IDLE, discards the job and sets timeout[i]; done[i] is not pulsed.
REQ-017 In XFER: busy[i]=1; the remaining-beat counter decrements on each cycle gnt[i]=1.
REQ-018 In XFER: when gnt[i]=1 and remaining=1, the channel moves to RELEASE; a len=N job therefore spends exactly N granted cycles in XFER.
REQ-019 In XFER: gnt[i]=0 (preemption) returns the channel to REQ with the remaining count kept and the wait counter cleared; that cycle consumes no beat.
REQ-020 In RELEASE: the channel waits for gnt[i]=0, then goes to IDLE with done[i]=1 in that transition cycle.
REQ-021 If the arbiter keeps gnt[i] high, the channel stays in RELEASE indefinitely with no timeout.
REQ-022 gnt[i]=1 seen in IDLE is ignored.
REQ-023 Simultaneous activity on both channels is independent; both may hold req=1 in the same cycle.
REQ-024 timeout[i] is cleared only by reset; new jobs are still accepted while it is set.

Reset
REQ-025 While reset=0 at a clock edge: both FSMs go to IDLE, counters go to 0, req=0, busy=0, done=0, timeout=0 and job_ready=0.
REQ-026 job_ready=2'b11 from the first cycle after reset deasserts.
REQ-027 Reset during XFER or REQ discards the job with no done pulse and drops req the following cycle.

Structure
REQ-028 A shared package holds the channel state enum (IDLE/REQ/XFER/RELEASE), the beat-counter width (4) and the wait-counter width (8).
REQ-029 One sub-module, req_channel, implements one FSM plus its counters; req_initiator instantiates it twice and concatenates the outputs.

Verification
REQ-030 Channel 0 job len=3, gnt[0] rises 2 cycles after req[0] and stays high -> busy[0] high exactly 3 cycles, req[0] drops, gnt low -> done[0] pulses once.
REQ-031 Channel 1 job, gnt[1] held 0, TIMEOUT=15 -> req[1] drops after 15 waiting cycles, timeout[1]=1, done[1] never pulses, job_ready[1]=1.
REQ-032 Channel 0 len=4, gnt[0] dropped for 3 cycles after 2 beats -> returns to REQ, resumes and completes after exactly 2 more granted beats.
REQ-033 Both channels len=1 accepted in the same cycle, gnt=2'b11 -> both complete, done=2'b11 in the same cycle.
REQ-034 Reset asserted mid-XFER on channel 0 (len=8, 3 beats done) -> next cycle req=0, busy=0, done=0, job_ready=0; after release, job_ready=2'b11.
REQ-035 job_len0=0 -> treated as a single beat: busy[0] high exactly 1 cycle.
